// File: rtl/fc_seq_pkg.sv
// rtl/fc_seq_pkg.sv - shared state encoding and default layer constants for the FC layer sequencer
package fc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        WAIT_W,
        MAC,
        LOAD_B,
        WAIT_B,
        WRITE,
        DONE
    } fc_seq_state_t;

    localparam int FC_IN_NODES  = 120;
    localparam int FC_OUT_NODES = 1200;

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// rtl/fc_layer_sequencer_if.sv - control, memory-request and MAC handshake bundle of the FC layer sequencer
interface fc_layer_sequencer_if #(
    parameter int ADDR_W = 11
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              err;
    logic              weights_en;
    logic [ADDR_W-1:0] weights_addr;
    logic              bias_en;
    logic [ADDR_W-1:0] bias_addr;
    logic              mac_start;
    logic              mac_done;
    logic              result_we;
    logic [ADDR_W-1:0] result_addr;

    modport master (
        input  start, abort, mac_done,
        output busy, done, err, weights_en, weights_addr, bias_en, bias_addr,
               mac_start, result_we, result_addr
    );

    modport slave (
        output start, abort, mac_done,
        input  busy, done, err, weights_en, weights_addr, bias_en, bias_addr,
               mac_start, result_we, result_addr
    );
endinterface

// File: rtl/fc_seq_delay_cnt.sv
// rtl/fc_seq_delay_cnt.sv - loadable down-counter with zero flag, shared by memory waits and the MAC watchdog
module fc_seq_delay_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/fc_layer_sequencer.sv
// rtl/fc_layer_sequencer.sv - per-node weight/bias fetch, MAC launch and result write sequencer for one FC layer
// Optional MAC watchdog enabled by defining FC_SEQ_TIMEOUT_EN.
module fc_layer_sequencer
    import fc_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int IN_NODES       = FC_IN_NODES,
    parameter int OUT_NODES      = FC_OUT_NODES,
    parameter int MEM_LAT        = 2,
    parameter int ADDR_W         = $clog2(OUT_NODES),
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    fc_layer_sequencer_if.master bus
);
    if (MEM_LAT < 1 || IN_NODES < 1 || DATA_WIDTH < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("fc_layer_sequencer: illegal parameter value");
    end

`ifdef FC_SEQ_TIMEOUT_EN
    localparam int CNT_MAX = (TIMEOUT_CYCLES > MEM_LAT) ? TIMEOUT_CYCLES : MEM_LAT;
`else
    localparam int CNT_MAX = MEM_LAT;
`endif
    localparam int                CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]  LAT_LD    = CNT_W'(MEM_LAT - 1);
    localparam logic [ADDR_W-1:0] LAST_NODE = ADDR_W'(OUT_NODES - 1);

    fc_seq_state_t     r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_node, w_node_nxt;
    logic              w_cnt_load, w_cnt_en, w_cnt_zero;
    logic [CNT_W-1:0]  w_cnt_val;
    logic              r_busy, r_done, r_weights_en, r_bias_en, r_mac_start, r_result_we;
    logic [ADDR_W-1:0] r_weights_addr, r_bias_addr, r_result_addr;
`ifdef FC_SEQ_TIMEOUT_EN
    logic              r_err, w_err_nxt;
`endif

    fc_seq_delay_cnt #(.CNT_W(CNT_W)) u_delay_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_en       (w_cnt_en),
        .i_load_val (w_cnt_val),
        .o_zero     (w_cnt_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_node_nxt  = r_node;
        w_cnt_load  = 1'b0;
        w_cnt_en    = 1'b0;
        w_cnt_val   = LAT_LD;
`ifdef FC_SEQ_TIMEOUT_EN
        w_err_nxt   = r_err;
`endif
        case (r_state)
            IDLE: if (bus.start) begin
                w_state_nxt = LOAD_W;
                w_node_nxt  = '0;
`ifdef FC_SEQ_TIMEOUT_EN
                w_err_nxt   = 1'b0;
`endif
            end
            LOAD_W: begin
                w_state_nxt = WAIT_W;
                w_cnt_load  = 1'b1;
            end
            WAIT_W: if (w_cnt_zero) begin
                w_state_nxt = MAC;
`ifdef FC_SEQ_TIMEOUT_EN
                w_cnt_load  = 1'b1;
                w_cnt_val   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
            end else begin
                w_cnt_en = 1'b1;
            end
            // r_mac_start is high only in the first MAC cycle, where mac_done is not trusted
            MAC: if (!r_mac_start && bus.mac_done) begin
                w_state_nxt = LOAD_B;
`ifdef FC_SEQ_TIMEOUT_EN
            end else if (w_cnt_zero) begin
                w_state_nxt = IDLE;
                w_node_nxt  = '0;
                w_err_nxt   = 1'b1;
            end else begin
                w_cnt_en = 1'b1;
`endif
            end
            LOAD_B: begin
                w_state_nxt = WAIT_B;
                w_cnt_load  = 1'b1;
            end
            WAIT_B: if (w_cnt_zero) begin
                w_state_nxt = WRITE;
            end else begin
                w_cnt_en = 1'b1;
            end
            WRITE: if (r_node == LAST_NODE) begin
                w_state_nxt = DONE;
            end else begin
                w_state_nxt = LOAD_W;
                w_node_nxt  = r_node + ADDR_W'(1);
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_node_nxt  = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_node_nxt  = '0;
            end
        endcase

        if ((r_state != IDLE) && bus.abort) begin
            w_state_nxt = IDLE;
            w_node_nxt  = '0;
            w_cnt_load  = 1'b0;
            w_cnt_en    = 1'b0;
`ifdef FC_SEQ_TIMEOUT_EN
            w_err_nxt   = r_err;
`endif
        end
    end

    // Outputs are decoded from the next state so every strobe is a plain register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_node         <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_weights_en   <= 1'b0;
            r_bias_en      <= 1'b0;
            r_mac_start    <= 1'b0;
            r_result_we    <= 1'b0;
            r_weights_addr <= '0;
            r_bias_addr    <= '0;
            r_result_addr  <= '0;
`ifdef FC_SEQ_TIMEOUT_EN
            r_err          <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_node       <= w_node_nxt;
            r_busy       <= (w_state_nxt != IDLE);
            r_done       <= (w_state_nxt == DONE);
            r_weights_en <= (w_state_nxt == LOAD_W);
            r_bias_en    <= (w_state_nxt == LOAD_B);
            r_mac_start  <= (w_state_nxt == MAC) && (r_state != MAC);
            r_result_we  <= (w_state_nxt == WRITE);
            if (w_state_nxt == LOAD_W) r_weights_addr <= w_node_nxt;
            if (w_state_nxt == LOAD_B) r_bias_addr    <= w_node_nxt;
            if (w_state_nxt == WRITE)  r_result_addr  <= w_node_nxt;
`ifdef FC_SEQ_TIMEOUT_EN
            r_err        <= w_err_nxt;
`endif
        end
    end

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.weights_en   = r_weights_en;
    assign bus.weights_addr = r_weights_addr;
    assign bus.bias_en      = r_bias_en;
    assign bus.bias_addr    = r_bias_addr;
    assign bus.mac_start    = r_mac_start;
    assign bus.result_we    = r_result_we;
    assign bus.result_addr  = r_result_addr;
`ifdef FC_SEQ_TIMEOUT_EN
    assign bus.err          = r_err;
`else
    assign bus.err          = 1'b0;
`endif
endmodule
